dram_rr_port_arbiter: RTL and testbench
=======================================

Name: dram_rr_port_arbiter

Overview:
- Parametrised successor to the fixed 8-queue DRAM interface arbiter in the DRAM output-queue subsystem.
- Shares one DRAM write channel and one DRAM read channel among NUM_PORTS dram_queue instances.
- Each channel has an independent grant FSM that picks the next requester in a single cycle using round-robin from last grant + 1, instead of scanning one port per cycle.
- Adds a per-channel done-timeout watchdog and grant status outputs.

Parameters:
- NUM_PORTS, 8, number of dram_queue clients; any value 2..16, not required to be a power of 2.
- DRAM_ADDR_WIDTH, 22, DRAM pointer width.
- DRAM_DATA_WIDTH, 144, DRAM word width.
- TIMEOUT, 1024, maximum BUSY cycles without done before a forced release; 0 disables the watchdog.
- PORT_WIDTH, log2(NUM_PORTS), grant index width; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dram_wr_req / dram_wr_data_vld  out  1  to DRAM write channel
- dram_wr_ptr  out  DRAM_ADDR_WIDTH
- dram_wr_data  out  DRAM_DATA_WIDTH
- dram_wr_ack / dram_wr_full / dram_wr_done  in  1  from DRAM
- dram_rd_req / dram_rd_en  out  1
- dram_rd_ptr  out  DRAM_ADDR_WIDTH
- dram_rd_data  in  DRAM_DATA_WIDTH
- dram_rd_ack / dram_rd_rdy / dram_rd_done  in  1
- wr_req_in / wr_data_vld_in  in  NUM_PORTS  per-port bits
- wr_ptr_in  in  NUM_PORTS*DRAM_ADDR_WIDTH  port p occupies slice p
- wr_data_in  in  NUM_PORTS*DRAM_DATA_WIDTH
- wr_ack_in / wr_full_in / wr_done_in  out  NUM_PORTS
- rd_req_in / rd_en_in  in  NUM_PORTS
- rd_ptr_in  in  NUM_PORTS*DRAM_ADDR_WIDTH
- rd_data_in  out  NUM_PORTS*DRAM_DATA_WIDTH
- rd_ack_in / rd_rdy_in / rd_done_in  out  NUM_PORTS
- wr_busy / rd_busy  out  1  channel is in BUSY
- wr_grant / rd_grant  out  PORT_WIDTH  currently granted port
- wr_timeout / rd_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- The write and read channels are identical and fully independent. The rules below use the write channel; the read channel mirrors them.
- Reset: state IDLE, grant 0, next-priority pointer 0, timeout counter 0.
  - All DRAM-side outputs are 0.
  - All per-port outputs are 0.
  - busy and timeout are 0.
  - Reset mid-transfer abandons the burst immediately; no done is forwarded.
- IDLE:
  - DRAM-side outputs are 0 and per-port returns are 0.
  - If any wr_req_in bit is set, register grant = first requesting port at or after the pointer, searching upward modulo NUM_PORTS.
  - Then go to BUSY. Latency is request to dram_wr_req = 1 cycle.
- BUSY:
  - dram_wr_req, dram_wr_data_vld, dram_wr_ptr and dram_wr_data are combinationally muxed from slice wr_grant.
  - dram_wr_ack, dram_wr_full and dram_wr_done are routed only to bit wr_grant; all other bits are 0.
  - Read channel: rd_data_in slice rd_grant = dram_rd_data; all other slices are 0.
  - If the granted port drops its request while BUSY, dram_wr_req follows it low and the grant is held.
- Exit BUSY:
  - On dram_wr_done = 1: next state IDLE, pointer = (grant+1) mod NUM_PORTS.
  - The minimum gap between grants is one IDLE cycle.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without done.
  - When the counter equals TIMEOUT-1 without done: go to IDLE, advance the pointer as on done, and pulse timeout for one cycle.
  - Done and timeout on the same cycle: done wins and there is no pulse.
- Wrap: the pointer and search wrap from NUM_PORTS-1 to 0 using explicit modulo, so non-power-of-2 counts never select an out-of-range port.
- DRAM return signals arriving while IDLE are ignored and not forwarded.

Test Plan:
- Reset, then only port 3 requests write → dram_wr_req high 1 cycle later; dram_wr_ptr = slice 3; wr_done_in only bit 3 on done; next pointer 4.
- All 8 ports request continuously, done 4 cycles after each grant → grants 0,1,2,…,7,0 in order, with exactly one IDLE cycle between grants.
- NUM_PORTS=5, ports 4 and 0 requesting, pointer 4 → grant 4, then 0; no index 5–7 ever appears.
- TIMEOUT=16, granted port 2 never gets done → wr_timeout pulses exactly once; IDLE on the 17th cycle after the grant; next requester granted.
- Read channel on port 6 with dram_rd_rdy and dram_rd_data=0xABC → rd_data_in slice 6 = 0xABC with other slices 0; rd_rdy_in = bit 6 only; simultaneous write to port 1 proceeds unaffected.
- Reset asserted mid-burst → next cycle all outputs 0, grant 0, busy 0; the first request after reset is served from port 0 priority.

Source files
------------

// File: rtl/dram_rr_port_arbiter_if.sv
// dram_rr_port_arbiter_if
//   Bundles every signal between the DRAM port arbiter, the shared DRAM
//   write/read channels and the NUM_PORTS dram_queue clients.
//   slave  : arbiter view. It drives the DRAM requests, the per-port
//            returns and the status outputs.
//   master : environment view (DRAM model plus queues). It drives the
//            DRAM returns and the per-port requests.
//   Signals:
//     DRAM write : dram_wr_req/data_vld/ptr/data (arbiter out),
//                  dram_wr_ack/full/done (arbiter in)
//     DRAM read  : dram_rd_req/en/ptr (arbiter out),
//                  dram_rd_data/ack/rdy/done (arbiter in)
//     per port   : wr_*_in / rd_*_in, one bit or slice per port
//     status     : wr/rd_busy, wr/rd_grant, wr/rd_timeout
interface dram_rr_port_arbiter_if #(
    parameter int NUM_PORTS       = 8,
    parameter int DRAM_ADDR_WIDTH = 22,
    parameter int DRAM_DATA_WIDTH = 144,
    parameter int PORT_WIDTH      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
);
    // DRAM write channel
    logic                                  dram_wr_req;
    logic                                  dram_wr_data_vld;
    logic [DRAM_ADDR_WIDTH-1:0]            dram_wr_ptr;
    logic [DRAM_DATA_WIDTH-1:0]            dram_wr_data;
    logic                                  dram_wr_ack;
    logic                                  dram_wr_full;
    logic                                  dram_wr_done;
    // DRAM read channel
    logic                                  dram_rd_req;
    logic                                  dram_rd_en;
    logic [DRAM_ADDR_WIDTH-1:0]            dram_rd_ptr;
    logic [DRAM_DATA_WIDTH-1:0]            dram_rd_data;
    logic                                  dram_rd_ack;
    logic                                  dram_rd_rdy;
    logic                                  dram_rd_done;
    // per-port write side
    logic [NUM_PORTS-1:0]                  wr_req_in;
    logic [NUM_PORTS-1:0]                  wr_data_vld_in;
    logic [NUM_PORTS*DRAM_ADDR_WIDTH-1:0]  wr_ptr_in;
    logic [NUM_PORTS*DRAM_DATA_WIDTH-1:0]  wr_data_in;
    logic [NUM_PORTS-1:0]                  wr_ack_in;
    logic [NUM_PORTS-1:0]                  wr_full_in;
    logic [NUM_PORTS-1:0]                  wr_done_in;
    // per-port read side
    logic [NUM_PORTS-1:0]                  rd_req_in;
    logic [NUM_PORTS-1:0]                  rd_en_in;
    logic [NUM_PORTS*DRAM_ADDR_WIDTH-1:0]  rd_ptr_in;
    logic [NUM_PORTS*DRAM_DATA_WIDTH-1:0]  rd_data_in;
    logic [NUM_PORTS-1:0]                  rd_ack_in;
    logic [NUM_PORTS-1:0]                  rd_rdy_in;
    logic [NUM_PORTS-1:0]                  rd_done_in;
    // status
    logic                                  wr_busy;
    logic                                  rd_busy;
    logic [PORT_WIDTH-1:0]                 wr_grant;
    logic [PORT_WIDTH-1:0]                 rd_grant;
    logic                                  wr_timeout;
    logic                                  rd_timeout;

    modport slave (
        input  dram_wr_ack, dram_wr_full, dram_wr_done,
        input  dram_rd_data, dram_rd_ack, dram_rd_rdy, dram_rd_done,
        input  wr_req_in, wr_data_vld_in, wr_ptr_in, wr_data_in,
        input  rd_req_in, rd_en_in, rd_ptr_in,
        output dram_wr_req, dram_wr_data_vld, dram_wr_ptr, dram_wr_data,
        output dram_rd_req, dram_rd_en, dram_rd_ptr,
        output wr_ack_in, wr_full_in, wr_done_in,
        output rd_data_in, rd_ack_in, rd_rdy_in, rd_done_in,
        output wr_busy, rd_busy, wr_grant, rd_grant, wr_timeout, rd_timeout
    );

    modport master (
        output dram_wr_ack, dram_wr_full, dram_wr_done,
        output dram_rd_data, dram_rd_ack, dram_rd_rdy, dram_rd_done,
        output wr_req_in, wr_data_vld_in, wr_ptr_in, wr_data_in,
        output rd_req_in, rd_en_in, rd_ptr_in,
        input  dram_wr_req, dram_wr_data_vld, dram_wr_ptr, dram_wr_data,
        input  dram_rd_req, dram_rd_en, dram_rd_ptr,
        input  wr_ack_in, wr_full_in, wr_done_in,
        input  rd_data_in, rd_ack_in, rd_rdy_in, rd_done_in,
        input  wr_busy, rd_busy, wr_grant, rd_grant, wr_timeout, rd_timeout
    );
endinterface

// File: rtl/dram_rr_port_arbiter.sv
// dram_rr_port_arbiter
//   Shares one DRAM write channel and one DRAM read channel among
//   NUM_PORTS dram_queue clients. Each channel runs its own IDLE/BUSY grant
//   FSM. The FSM picks the next requester in one cycle, round-robin
//   starting from the port after the last grant. A watchdog forces a
//   release when done does not arrive within TIMEOUT BUSY cycles.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high
//     bus   : dram_rr_port_arbiter_if.slave. It carries the DRAM channels,
//             the per-port request/return bundles and the grant status
//             (busy, grant, timeout pulse) for each channel.
module dram_rr_port_arbiter #(
    parameter int NUM_PORTS       = 8,
    parameter int DRAM_ADDR_WIDTH = 22,
    parameter int DRAM_DATA_WIDTH = 144,
    parameter int TIMEOUT         = 1024,
    parameter int PORT_WIDTH      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    dram_rr_port_arbiter_if.slave  bus
);

    localparam int unsigned NP    = NUM_PORTS;
    localparam int unsigned AW    = DRAM_ADDR_WIDTH;
    localparam int unsigned DW    = DRAM_DATA_WIDTH;
    localparam int          CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // First requester at or after ptr, wrapping modulo NUM_PORTS. The
    // request vector is doubled and shifted down by ptr, so the wrap is
    // plain bit positions. The winning offset is then folded back into
    // range with an explicit subtract.
    function automatic logic [PORT_WIDTH-1:0] rr_pick(
        input logic [NUM_PORTS-1:0]  req,
        input logic [PORT_WIDTH-1:0] ptr
    );
        logic [2*NUM_PORTS-1:0] dbl;
        logic [NUM_PORTS-1:0]   rot;
        logic [PORT_WIDTH-1:0]  sel;
        logic                   found;
        int unsigned            sum;
        dbl   = {req, req};
        rot   = NUM_PORTS'(dbl >> ptr);
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (!found && rot[i]) begin
                sum = 32'(ptr) + i;
                if (sum >= NP) begin
                    sum = sum - NP;
                end
                sel   = PORT_WIDTH'(sum);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PORT_WIDTH-1:0] next_ptr(input logic [PORT_WIDTH-1:0] g);
        if (32'(g) == NP - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // Index 0 is the write channel and index 1 is the read channel.
    logic [NUM_PORTS-1:0]  ch_req   [2];
    logic                  ch_done  [2];
    logic                  ch_busy  [2];
    logic [PORT_WIDTH-1:0] ch_grant [2];
    logic                  ch_to    [2];

    assign ch_req[0]  = bus.wr_req_in;
    assign ch_req[1]  = bus.rd_req_in;
    assign ch_done[0] = bus.dram_wr_done;
    assign ch_done[1] = bus.dram_rd_done;

    for (genvar c = 0; c < 2; c++) begin : g_chan
        state_t                state_q, state_d;
        logic [PORT_WIDTH-1:0] grant_q, grant_d;
        logic [PORT_WIDTH-1:0] ptr_q, ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  to_q, to_d;
        logic                  wd_expired;

        assign wd_expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                grant_q <= '0;
                ptr_q   <= '0;
                cnt_q   <= '0;
                to_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                grant_q <= grant_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
                to_q    <= to_d;
            end
        end

        always_comb begin
            state_d = state_q;
            grant_d = grant_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            to_d    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (|ch_req[c]) begin
                        grant_d = rr_pick(ch_req[c], ptr_q);
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    // done has priority over the watchdog on the same cycle
                    if (ch_done[c]) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr(grant_q);
                    end else if (wd_expired) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr(grant_q);
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign ch_busy[c]  = (state_q == BUSY);
        assign ch_grant[c] = grant_q;
        assign ch_to[c]    = to_q;
    end

    // Datapath steering: only the granted slice is connected while BUSY;
    // everything else, including DRAM returns seen in IDLE, reads as zero.
    logic                  wr_req_mux, wr_vld_mux, rd_req_mux, rd_en_mux;
    logic [AW-1:0]         wr_ptr_mux, rd_ptr_mux;
    logic [DW-1:0]         wr_data_mux;
    logic [NUM_PORTS-1:0]  wr_ack_mux, wr_full_mux, wr_done_mux;
    logic [NUM_PORTS-1:0]  rd_ack_mux, rd_rdy_mux, rd_done_mux;
    logic [NUM_PORTS*DRAM_DATA_WIDTH-1:0] rd_data_mux;

    always_comb begin
        wr_req_mux  = 1'b0;
        wr_vld_mux  = 1'b0;
        wr_ptr_mux  = '0;
        wr_data_mux = '0;
        wr_ack_mux  = '0;
        wr_full_mux = '0;
        wr_done_mux = '0;
        rd_req_mux  = 1'b0;
        rd_en_mux   = 1'b0;
        rd_ptr_mux  = '0;
        rd_data_mux = '0;
        rd_ack_mux  = '0;
        rd_rdy_mux  = '0;
        rd_done_mux = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            if (ch_busy[0] && ch_grant[0] == PORT_WIDTH'(p)) begin
                wr_req_mux     = bus.wr_req_in[p];
                wr_vld_mux     = bus.wr_data_vld_in[p];
                wr_ptr_mux     = bus.wr_ptr_in[p*AW +: AW];
                wr_data_mux    = bus.wr_data_in[p*DW +: DW];
                wr_ack_mux[p]  = bus.dram_wr_ack;
                wr_full_mux[p] = bus.dram_wr_full;
                wr_done_mux[p] = bus.dram_wr_done;
            end
            if (ch_busy[1] && ch_grant[1] == PORT_WIDTH'(p)) begin
                rd_req_mux             = bus.rd_req_in[p];
                rd_en_mux              = bus.rd_en_in[p];
                rd_ptr_mux             = bus.rd_ptr_in[p*AW +: AW];
                rd_data_mux[p*DW +: DW] = bus.dram_rd_data;
                rd_ack_mux[p]          = bus.dram_rd_ack;
                rd_rdy_mux[p]          = bus.dram_rd_rdy;
                rd_done_mux[p]         = bus.dram_rd_done;
            end
        end
    end

    assign bus.dram_wr_req      = wr_req_mux;
    assign bus.dram_wr_data_vld = wr_vld_mux;
    assign bus.dram_wr_ptr      = wr_ptr_mux;
    assign bus.dram_wr_data     = wr_data_mux;
    assign bus.wr_ack_in        = wr_ack_mux;
    assign bus.wr_full_in       = wr_full_mux;
    assign bus.wr_done_in       = wr_done_mux;
    assign bus.dram_rd_req      = rd_req_mux;
    assign bus.dram_rd_en       = rd_en_mux;
    assign bus.dram_rd_ptr      = rd_ptr_mux;
    assign bus.rd_data_in       = rd_data_mux;
    assign bus.rd_ack_in        = rd_ack_mux;
    assign bus.rd_rdy_in        = rd_rdy_mux;
    assign bus.rd_done_in       = rd_done_mux;
    assign bus.wr_busy          = ch_busy[0];
    assign bus.rd_busy          = ch_busy[1];
    assign bus.wr_grant         = ch_grant[0];
    assign bus.rd_grant         = ch_grant[1];
    assign bus.wr_timeout       = ch_to[0];
    assign bus.rd_timeout       = ch_to[1];

endmodule

// File: tb/tb_dram_rr_port_arbiter.sv
// tb_dram_rr_port_arbiter
//   Bench for dram_rr_port_arbiter. It has two instances: an 8-port one
//   with TIMEOUT=16 and a 5-port one with the watchdog disabled. Directed
//   steps come first, then randomized traffic. Every cycle the outputs are
//   compared with a transaction-level reference model.
module tb_dram_rr_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dram_rr_port_arbiter_if #(.NUM_PORTS(8), .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) if8 ();
    dram_rr_port_arbiter_if #(.NUM_PORTS(5), .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) if5 ();

    dram_rr_port_arbiter #(.NUM_PORTS(8), .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .TIMEOUT(16))
        u_dut8 (.clk(clk), .reset(reset), .bus(if8));
    dram_rr_port_arbiter #(.NUM_PORTS(5), .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .TIMEOUT(0))
        u_dut5 (.clk(clk), .reset(reset), .bus(if5));

    // Reference model, one entry per channel:
    // 0 = 8-port wr, 1 = 8-port rd, 2 = 5-port wr, 3 = 5-port rd.
    // mb busy, mg owner, mp port searched first, ma BUSY cycles completed,
    // mt timeout pulse.
    int mb [4];
    int mg [4];
    int mp [4];
    int ma [4];
    int mt [4];

    task automatic tick_model(input int k, input int n, input int t, input int req, input bit done);
        if (reset) begin
            mb[k] = 0; mg[k] = 0; mp[k] = 0; ma[k] = 0; mt[k] = 0;
        end else begin
            mt[k] = 0;
            if (mb[k] == 0) begin
                if (req != 0) begin
                    for (int i = 0; i < n; i++) begin
                        if (req[(mp[k] + i) % n]) begin
                            mg[k] = (mp[k] + i) % n;
                            break;
                        end
                    end
                    mb[k] = 1;
                    ma[k] = 0;
                end
            end else begin
                ma[k] = ma[k] + 1;
                if (done || (t != 0 && ma[k] == t)) begin
                    mb[k] = 0;
                    mp[k] = (mg[k] + 1) % n;
                    mt[k] = done ? 0 : 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] route(input int b, input int g, input logic v);
        return (b != 0) ? (256'(v) << g) : '0;
    endfunction

    task automatic check_all();
        int g;
        g = mg[0];
        chk("wr_busy", if8.wr_busy, mb[0]);
        chk("wr_timeout", if8.wr_timeout, mt[0]);
        if (mb[0] != 0) chk("wr_grant", if8.wr_grant, g);
        chk("dram_wr_req", if8.dram_wr_req, (mb[0] != 0) && if8.wr_req_in[g]);
        chk("dram_wr_vld", if8.dram_wr_data_vld, (mb[0] != 0) && if8.wr_data_vld_in[g]);
        chk("dram_wr_ptr", if8.dram_wr_ptr, (mb[0] != 0) ? if8.wr_ptr_in[g*AW +: AW] : '0);
        chk("dram_wr_data", if8.dram_wr_data, (mb[0] != 0) ? if8.wr_data_in[g*DW +: DW] : '0);
        chk("wr_ack_in", if8.wr_ack_in, route(mb[0], g, if8.dram_wr_ack));
        chk("wr_full_in", if8.wr_full_in, route(mb[0], g, if8.dram_wr_full));
        chk("wr_done_in", if8.wr_done_in, route(mb[0], g, if8.dram_wr_done));
        g = mg[1];
        chk("rd_busy", if8.rd_busy, mb[1]);
        chk("rd_timeout", if8.rd_timeout, mt[1]);
        if (mb[1] != 0) chk("rd_grant", if8.rd_grant, g);
        chk("dram_rd_req", if8.dram_rd_req, (mb[1] != 0) && if8.rd_req_in[g]);
        chk("dram_rd_en", if8.dram_rd_en, (mb[1] != 0) && if8.rd_en_in[g]);
        chk("dram_rd_ptr", if8.dram_rd_ptr, (mb[1] != 0) ? if8.rd_ptr_in[g*AW +: AW] : '0);
        chk("rd_data_in", if8.rd_data_in, (mb[1] != 0) ? (256'(if8.dram_rd_data) << (g*DW)) : '0);
        chk("rd_ack_in", if8.rd_ack_in, route(mb[1], g, if8.dram_rd_ack));
        chk("rd_rdy_in", if8.rd_rdy_in, route(mb[1], g, if8.dram_rd_rdy));
        chk("rd_done_in", if8.rd_done_in, route(mb[1], g, if8.dram_rd_done));
        // 5-port instance
        chk("p5_wr_busy", if5.wr_busy, mb[2]);
        chk("p5_wr_range", if5.wr_grant < 5, 1);
        chk("p5_rd_range", if5.rd_grant < 5, 1);
        if (mb[2] != 0) chk("p5_wr_grant", if5.wr_grant, mg[2]);
        chk("p5_wr_timeout", if5.wr_timeout, 0);
        chk("p5_dram_wr_req", if5.dram_wr_req, (mb[2] != 0) && if5.wr_req_in[mg[2]]);
        chk("p5_wr_done_in", if5.wr_done_in, route(mb[2], mg[2], if5.dram_wr_done));
        chk("p5_rd_busy", if5.rd_busy, mb[3]);
        if (mb[3] != 0) chk("p5_rd_grant", if5.rd_grant, mg[3]);
        chk("p5_rd_rdy_in", if5.rd_rdy_in, route(mb[3], mg[3], if5.dram_rd_rdy));
    endtask

    // Inputs are applied just after a falling edge. Outputs are checked
    // 1 ns later, and the model advances on the rising edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        tick_model(0, 8, 16, int'(if8.wr_req_in), if8.dram_wr_done);
        tick_model(1, 8, 16, int'(if8.rd_req_in), if8.dram_rd_done);
        tick_model(2, 5, 0, int'(if5.wr_req_in), if5.dram_wr_done);
        tick_model(3, 5, 0, int'(if5.rd_req_in), if5.dram_rd_done);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if8.wr_req_in = '0; if8.wr_data_vld_in = '0; if8.wr_ptr_in = '0; if8.wr_data_in = '0;
        if8.rd_req_in = '0; if8.rd_en_in = '0; if8.rd_ptr_in = '0;
        if8.dram_wr_ack = 0; if8.dram_wr_full = 0; if8.dram_wr_done = 0;
        if8.dram_rd_data = '0; if8.dram_rd_ack = 0; if8.dram_rd_rdy = 0; if8.dram_rd_done = 0;
        if5.wr_req_in = '0; if5.wr_data_vld_in = '0; if5.wr_ptr_in = '0; if5.wr_data_in = '0;
        if5.rd_req_in = '0; if5.rd_en_in = '0; if5.rd_ptr_in = '0;
        if5.dram_wr_ack = 0; if5.dram_wr_full = 0; if5.dram_wr_done = 0;
        if5.dram_rd_data = '0; if5.dram_rd_ack = 0; if5.dram_rd_rdy = 0; if5.dram_rd_done = 0;
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 3) == 0) if8.wr_req_in = 8'($urandom);
        if ($urandom_range(0, 3) == 0) if8.rd_req_in = 8'($urandom);
        if ($urandom_range(0, 3) == 0) if5.wr_req_in = 5'($urandom);
        if ($urandom_range(0, 3) == 0) if5.rd_req_in = 5'($urandom);
        if8.wr_data_vld_in = 8'($urandom);
        if8.rd_en_in       = 8'($urandom);
        for (int p = 0; p < 8; p++) begin
            if8.wr_ptr_in[p*AW +: AW]  = AW'($urandom);
            if8.rd_ptr_in[p*AW +: AW]  = AW'($urandom);
            if8.wr_data_in[p*DW +: DW] = $urandom;
        end
        if8.dram_wr_ack  = 1'($urandom);
        if8.dram_wr_full = 1'($urandom);
        if8.dram_wr_done = ($urandom_range(0, 9) == 0);
        if8.dram_rd_data = $urandom;
        if8.dram_rd_ack  = 1'($urandom);
        if8.dram_rd_rdy  = 1'($urandom);
        if8.dram_rd_done = ($urandom_range(0, 9) == 0);
        if5.dram_wr_done = ($urandom_range(0, 7) == 0);
        if5.dram_rd_done = ($urandom_range(0, 7) == 0);
        if5.dram_rd_rdy  = 1'($urandom);
        reset = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int ng;
        int idle_run;
        int bc;
        int tc;
        bit prev;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 4; k++) begin
            mb[k] = 0; mg[k] = 0; mp[k] = 0; ma[k] = 0; mt[k] = 0;
        end
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        reset = 1'b0;
        chk("reset_wr_busy", if8.wr_busy, 0);
        chk("reset_wr_grant", if8.wr_grant, 0);
        chk("reset_rd_grant", if8.rd_grant, 0);

        // Port 3 alone: one cycle of latency, slice 3 is muxed, and done
        // is routed to bit 3 only. The pointer then moves to 4.
        for (int p = 0; p < 8; p++) begin
            if8.wr_ptr_in[p*AW +: AW]  = AW'(32'h100 + p);
            if8.wr_data_in[p*DW +: DW] = 32'hD000 + p;
        end
        if8.wr_req_in = 8'h08;
        if8.wr_data_vld_in = 8'h08;
        #1 chk("t1_idle_req", if8.dram_wr_req, 0);
        cycle();
        #1 chk("t1_req", if8.dram_wr_req, 1);
        chk("t1_ptr", if8.dram_wr_ptr, 22'h103);
        if8.dram_wr_done = 1;
        #1 chk("t1_done_bit3", if8.wr_done_in, 8'h08);
        cycle();
        if8.dram_wr_done = 0;
        if8.wr_req_in = '0;
        cycle();
        if8.wr_req_in = 8'h24;
        cycle();
        chk("t1_next_from_ptr4", if8.wr_grant, 5);
        if8.dram_wr_done = 1;
        cycle();
        clear_inputs();

        // All eight ports request and done comes in the 4th BUSY cycle:
        // grants 0..7 then 0, with exactly one IDLE cycle between grants.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        if8.wr_req_in = 8'hFF;
        ng = 0;
        idle_run = 0;
        prev = 0;
        for (int cyc = 0; cyc < 120 && ng < 9; cyc++) begin
            if8.dram_wr_done = (mb[0] != 0 && ma[0] == 3);
            if (if8.wr_busy && !prev) begin
                chk("t2_grant_order", if8.wr_grant, ng % 8);
                if (ng > 0) chk("t2_idle_gap", idle_run, 1);
                ng++;
                idle_run = 0;
            end
            if (!if8.wr_busy) idle_run++;
            prev = if8.wr_busy;
            cycle();
        end
        chk("t2_grant_count", ng, 9);
        if8.wr_req_in = '0;
        if8.dram_wr_done = 1;
        cycle();
        clear_inputs();

        // Watchdog: port 2 never receives done. After 16 BUSY cycles the
        // channel goes IDLE with a single pulse, and port 5 is served next.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        if8.wr_req_in = 8'h24;
        cycle();
        chk("t3_grant", if8.wr_grant, 2);
        bc = 0;
        tc = 0;
        for (int i = 0; i < 16; i++) begin
            bc += int'(if8.wr_busy);
            tc += int'(if8.wr_timeout);
            cycle();
        end
        chk("t3_busy_cycles", bc, 16);
        chk("t3_no_early_pulse", tc, 0);
        chk("t3_idle_17th", if8.wr_busy, 0);
        chk("t3_pulse", if8.wr_timeout, 1);
        cycle();
        chk("t3_pulse_once", if8.wr_timeout, 0);
        chk("t3_next_grant", if8.wr_grant, 5);
        if8.dram_wr_done = 1;
        cycle();
        clear_inputs();

        // Read on port 6 runs alongside a write on port 1.
        for (int p = 0; p < 8; p++) begin
            if8.wr_ptr_in[p*AW +: AW] = AW'(32'h100 + p);
            if8.rd_ptr_in[p*AW +: AW] = AW'(32'h200 + p);
        end
        if8.rd_req_in = 8'h40;
        if8.rd_en_in  = 8'h40;
        if8.wr_req_in = 8'h02;
        cycle();
        if8.dram_rd_rdy  = 1;
        if8.dram_rd_data = 32'hABC;
        #1 chk("t4_rd_data_slice6", if8.rd_data_in, 256'hABC << 192);
        chk("t4_rd_rdy_bit6", if8.rd_rdy_in, 8'h40);
        chk("t4_rd_ptr", if8.dram_rd_ptr, 22'h206);
        chk("t4_wr_grant", if8.wr_grant, 1);
        chk("t4_wr_ptr", if8.dram_wr_ptr, 22'h101);
        if8.dram_rd_done = 1;
        if8.dram_wr_done = 1;
        cycle();
        clear_inputs();

        // Reset in the middle of a burst clears everything at once, and the
        // first grant after reset searches from port 0.
        if8.wr_req_in = 8'h20;
        if8.rd_req_in = 8'h08;
        cycle();
        chk("t5_busy_before", if8.wr_busy, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t5_wr_busy", if8.wr_busy, 0);
        chk("t5_rd_busy", if8.rd_busy, 0);
        chk("t5_wr_grant", if8.wr_grant, 0);
        chk("t5_dram_wr_req", if8.dram_wr_req, 0);
        if8.wr_req_in = 8'h84;
        cycle();
        chk("t5_first_grant", if8.wr_grant, 2);
        if8.dram_wr_done = 1;
        if8.dram_rd_done = 1;
        cycle();
        clear_inputs();

        // Five ports: move the pointer to 4, then ports 4 and 0 are served
        // in that order.
        if5.wr_req_in = 5'b01000;
        cycle();
        chk("t6_grant3", if5.wr_grant, 3);
        if5.dram_wr_done = 1;
        cycle();
        if5.dram_wr_done = 0;
        if5.wr_req_in = 5'b10001;
        cycle();
        chk("t6_grant4", if5.wr_grant, 4);
        if5.dram_wr_done = 1;
        cycle();
        if5.dram_wr_done = 0;
        cycle();
        chk("t6_grant0", if5.wr_grant, 0);
        if5.dram_wr_done = 1;
        cycle();
        clear_inputs();

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
